truth_table_extractor: RTL

- Characterises an N-input, 1-output combinational gate, such as the 3-input case modules, by sweeping all 2^N input combinations and sampling the output after a settle window.
- Assembles the truth-table hex code in the same row order the case modules are named by: row 000 is the MSB and row 111 is the LSB, so a table of 1,0,0,0,1,0,0,1 reads 8'h89.
- Sits beside a gate instance in characterisation and regression benches.
- It is the reader of what a case module writes.

---
 rtl/truth_table_extractor_pkg.sv | 24 ++
 rtl/truth_table_extractor_settle_timer.sv | 35 +++
 rtl/truth_table_extractor.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/truth_table_extractor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_extractor_pkg
// Brief    : Shared sweep state encoding and truth-table row/bit mapping.
// Revision : 1.0 - initial release
// ============================================================================
package truth_table_extractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tte_state_e;

    localparam int c_max_inputs = 4;

    // Row 0 lands in the MSB so the table reads in case-module naming order.
    function automatic int tt_bit_index(input int row, input int n);
        return (2 ** n) - 1 - row;
    endfunction

endpackage : truth_table_extractor_pkg
`default_nettype wire

// File: rtl/truth_table_extractor_settle_timer.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_extractor_settle_timer
// Brief    : Settle counter; flags the last cycle a gate input is allowed to settle.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_extractor_settle_timer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_count,
    output logic o_expired
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_count) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_count && (r_cnt == c_last);

endmodule : truth_table_extractor_settle_timer
`default_nettype wire

// File: rtl/truth_table_extractor.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_extractor
// Brief    : Sweeps all input rows of an N-input gate and assembles its truth-table code.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_extractor
    import truth_table_extractor_pkg::*;
#(
    parameter int N_INPUTS      = 3,
    parameter int TT_WIDTH      = 2 ** N_INPUTS,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic [N_INPUTS-1:0] drive,
    input  logic                sample,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [TT_WIDTH-1:0] result_table,
    output logic                result_unstable
);

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("truth_table_extractor: SETTLE_CYCLES must be >= 1");
        end
        if ((N_INPUTS < 1) || (N_INPUTS > c_max_inputs)) begin : g_bad_inputs
            $error("truth_table_extractor: N_INPUTS must be in 1..4");
        end
        if (TT_WIDTH != (2 ** N_INPUTS)) begin : g_bad_width
            $error("truth_table_extractor: TT_WIDTH must equal 2**N_INPUTS");
        end
    endgenerate

    localparam logic [1:0] c_st_idle   = ST_IDLE;
    localparam logic [1:0] c_st_settle = ST_SETTLE;
    localparam logic [1:0] c_st_sample = ST_SAMPLE;
    localparam logic [1:0] c_st_done   = ST_DONE;

    localparam logic [N_INPUTS-1:0] c_last_row = N_INPUTS'(TT_WIDTH - 1);

    logic [1:0]          r_state;
    logic [N_INPUTS-1:0] r_drive;
    logic [TT_WIDTH-1:0] r_shift;
    logic                r_unst_acc;
    logic                r_prev_sample;
    logic [TT_WIDTH-1:0] r_result_table;
    logic                r_result_unstable;

    logic                w_in_settle;
    logic                w_timer_expired;
    logic                w_last_row;
    logic                w_sample_moved;
    logic [N_INPUTS-1:0] w_bit_idx;
    logic [TT_WIDTH-1:0] w_shift_next;

    assign w_in_settle    = (r_state == c_st_settle);
    assign w_last_row     = (r_drive == c_last_row);
    assign w_sample_moved = (sample != r_prev_sample);
    assign w_bit_idx      = N_INPUTS'(tt_bit_index(int'(r_drive), N_INPUTS));

    // The counter sits at zero outside SETTLE, so every SETTLE entry starts a fresh window.
    truth_table_extractor_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk       (clk),
        .rst       (reset),
        .i_load    (!w_in_settle),
        .i_count   (w_in_settle),
        .o_expired (w_timer_expired)
    );

    always_comb begin
        w_shift_next            = r_shift;
        w_shift_next[w_bit_idx] = sample;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= c_st_idle;
            r_drive           <= '0;
            r_shift           <= '0;
            r_unst_acc        <= 1'b0;
            r_prev_sample     <= 1'b0;
            r_result_table    <= '0;
            r_result_unstable <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state    <= c_st_settle;
                        r_drive    <= '0;
                        r_shift    <= '0;
                        r_unst_acc <= 1'b0;
                    end
                end
                c_st_settle: begin
                    r_prev_sample <= sample;
                    if (w_timer_expired) begin
                        r_state <= c_st_sample;
                    end
                end
                c_st_sample: begin
                    r_shift <= w_shift_next;
                    if (w_sample_moved) begin
                        r_unst_acc <= 1'b1;
                    end
                    // Results are published on DONE entry so they stay put during the next sweep.
                    if (w_last_row) begin
                        r_state           <= c_st_done;
                        r_result_table    <= w_shift_next;
                        r_result_unstable <= r_unst_acc | w_sample_moved;
                    end else begin
                        r_drive <= r_drive + 1'b1;
                        r_state <= c_st_settle;
                    end
                end
                c_st_done: begin
                    if (result_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign busy            = (r_state == c_st_settle) || (r_state == c_st_sample);
    assign result_valid    = (r_state == c_st_done);
    assign drive           = r_drive;
    assign result_table    = r_result_table;
    assign result_unstable = r_result_unstable;

endmodule : truth_table_extractor
`default_nettype wire
